// File: rtl/alu32_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : alu32_rr_arbiter
//  Description : Shared add/sub datapath for two requesters. A round-robin
//                arbiter picks one operation per cycle. The result and flags
//                go into a single-entry output register that is tagged with
//                the requester id and drained by a valid/ready handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu32_rr_arbiter #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,

    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic             req0_sub_add,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,

    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic             req1_sub_add,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,

    output logic             resp_valid,
    input  logic             resp_ready,
    output logic             resp_id,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             zero,
    output logic             overflow,
    output logic [CNT_W-1:0] op_count
);

    localparam logic [0:0] S_EMPTY = 1'b0;
    localparam logic [0:0] S_FULL  = 1'b1;

    logic [0:0]       r_state;
    logic [0:0]       w_stateNext;
    logic             r_prio;
    logic             r_respId;
    logic [WIDTH-1:0] r_result;
    logic             r_carry;
    logic             r_zero;
    logic             r_overflow;
    logic [CNT_W-1:0] r_opCount;

    logic             w_canAccept;
    logic             w_grantValid;
    logic             w_grantId;
    logic             w_xfer;
    logic             w_consume;
    logic             w_subAdd;
    logic [WIDTH-1:0] w_a;
    logic [WIDTH-1:0] w_b;
    logic [WIDTH-1:0] w_bx;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH-1:0] w_result;
    logic             w_overflow;

    // Arbitration: prefer r_prio when both ask; readies are suppressed in reset
    always_comb begin
        w_canAccept  = !rst && ((r_state == S_EMPTY) || resp_ready);
        w_grantValid = req0_valid || req1_valid;
        w_grantId    = (req0_valid && req1_valid) ? r_prio : req1_valid;
        w_xfer       = w_canAccept && w_grantValid;
        req0_ready   = w_xfer && !w_grantId;
        req1_ready   = w_xfer && w_grantId;
        w_consume    = (r_state == S_FULL) && resp_ready;
    end

    // Datapath: subtract is a + ~b + 1 so carry=1 means no borrow
    always_comb begin
        w_subAdd   = w_grantId ? req1_sub_add : req0_sub_add;
        w_a        = w_grantId ? req1_a : req0_a;
        w_b        = w_grantId ? req1_b : req0_b;
        w_bx       = w_b ^ {WIDTH{w_subAdd}};
        w_sum      = {1'b0, w_a} + {1'b0, w_bx} + {{WIDTH{1'b0}}, w_subAdd};
        w_result   = w_sum[WIDTH-1:0];
        w_overflow = (w_a[WIDTH-1] == w_bx[WIDTH-1]) &&
                     (w_result[WIDTH-1] != w_a[WIDTH-1]);
    end

    // Output register occupancy: a grant always refills, a drain alone empties
    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            S_EMPTY: if (w_xfer) w_stateNext = S_FULL;
            S_FULL: begin
                if (w_xfer)          w_stateNext = S_FULL;
                else if (resp_ready) w_stateNext = S_EMPTY;
            end
            default: w_stateNext = S_EMPTY;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_EMPTY;
        else     r_state <= w_stateNext;
    end

    // Result/flag register: loads on every accepted operation, else holds
    always_ff @(posedge clk) begin
        if (rst) begin
            r_respId   <= 1'b0;
            r_result   <= '0;
            r_carry    <= 1'b0;
            r_zero     <= 1'b0;
            r_overflow <= 1'b0;
        end else if (w_xfer) begin
            r_respId   <= w_grantId;
            r_result   <= w_result;
            r_carry    <= w_sum[WIDTH];
            r_zero     <= ~|w_result;
            r_overflow <= w_overflow;
        end
    end

    // Round-robin pointer: the requester just served loses priority
    always_ff @(posedge clk) begin
        if (rst)         r_prio <= 1'b0;
        else if (w_xfer) r_prio <= ~w_grantId;
    end

    // Completed-response counter, wraps naturally
    always_ff @(posedge clk) begin
        if (rst)            r_opCount <= '0;
        else if (w_consume) r_opCount <= r_opCount + {{(CNT_W-1){1'b0}}, 1'b1};
    end

    assign resp_valid = (r_state == S_FULL);
    assign resp_id    = r_respId;
    assign result     = r_result;
    assign carry      = r_carry;
    assign zero       = r_zero;
    assign overflow   = r_overflow;
    assign op_count   = r_opCount;

endmodule
`default_nettype wire
